uart_rx: RTL

- UART serial receiver using 16x oversampling. Consumes the one-clock `tick` strobe from the team's baud-rate generator on its `s_tick` input.
- Recovers 8N1 frames by default, with optional parity, LSB first. Presents each byte on a parallel bus with a one-clock done strobe and error flags.
- Sits between the board RX pin and the UART RX FIFO / bus-side register block.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the future transmitter.
//   state_t        - receiver/transmitter frame state
//   PAR_*          - parity mode encodings for the PAR_MODE parameter
//   OVERSAMPLE     - s_tick strobes per bit period
//   MID_START      - tick index that lands in the middle of the start bit
//   parity_bad()   - parity check helper for a received frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

    // data_xor is the XOR reduction of the data word, par_bit the received
    // parity bit; returns 1 when the pair violates the selected parity.
    function automatic logic parity_bad(input logic data_xor,
                                        input logic par_bit,
                                        input int   mode);
        logic bad;
        case (mode)
            PAR_EVEN: bad = data_xor ^ par_bit;
            PAR_ODD:  bad = ~(data_xor ^ par_bit);
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for an asynchronous single-bit input.
//   clk    - destination clock
//   reset  - asynchronous active-high reset, loads RST_VAL into both flops
//   d      - asynchronous input
//   q      - synchronized output (2 clk latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_r;

    // Two-stage shift toward the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {2{RST_VAL}};
        end else begin
            sync_r <= {sync_r[0], d};
        end
    end

    assign q = sync_r[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB first, optional parity.
//   clk          - system clock
//   reset        - asynchronous active-high reset
//   s_tick       - one-clk oversample strobe, 16 per bit period
//   rx           - asynchronous serial input, idle high
//   dout         - last received data word
//   rx_done_tick - one-clk pulse when a frame completes
//   frame_err    - stop bit was sampled low on the last frame
//   parity_err   - parity mismatch on the last frame (0 when PAR_MODE=0)
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int PAR_MODE = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam logic [4:0] S_MID       = 5'(MID_START);
    localparam logic [4:0] S_BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    logic            rx_s;
    state_t          state_r,      state_next_s;
    logic [4:0]      s_cnt_r,      s_cnt_next_s;
    logic [2:0]      n_cnt_r,      n_cnt_next_s;
    logic [DBIT-1:0] b_reg_r,      b_reg_next_s;
    logic            par_bad_r,    par_bad_next_s;
    logic [DBIT-1:0] dout_r,       dout_next_s;
    logic            done_r,       done_next_s;
    logic            frame_err_r,  frame_err_next_s;
    logic            parity_err_r, parity_err_next_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            s_cnt_r      <= 5'd0;
            n_cnt_r      <= 3'd0;
            b_reg_r      <= '0;
            par_bad_r    <= 1'b0;
            dout_r       <= '0;
            done_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            s_cnt_r      <= s_cnt_next_s;
            n_cnt_r      <= n_cnt_next_s;
            b_reg_r      <= b_reg_next_s;
            par_bad_r    <= par_bad_next_s;
            dout_r       <= dout_next_s;
            done_r       <= done_next_s;
            frame_err_r  <= frame_err_next_s;
            parity_err_r <= parity_err_next_s;
        end
    end

    // Next-state decode; every transition except IDLE->START waits on s_tick.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx_s) state_next_s = START;
                else       state_next_s = IDLE;
            end
            START: begin
                // Line back high at mid start bit means it was a glitch.
                if (s_tick && (s_cnt_r == S_MID)) state_next_s = rx_s ? IDLE : DATA;
                else                              state_next_s = START;
            end
            DATA: begin
                if (s_tick && (s_cnt_r == S_BIT_LAST) && (n_cnt_r == N_LAST))
                    state_next_s = (PAR_MODE != PAR_NONE) ? PARITY : STOP;
                else
                    state_next_s = DATA;
            end
            PARITY: begin
                if (s_tick && (s_cnt_r == S_BIT_LAST)) state_next_s = STOP;
                else                                   state_next_s = PARITY;
            end
            STOP: begin
                if (s_tick && (s_cnt_r == S_STOP_LAST)) state_next_s = IDLE;
                else                                    state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Counter, shift register and output updates for the current state.
    always_comb begin
        s_cnt_next_s      = s_cnt_r;
        n_cnt_next_s      = n_cnt_r;
        b_reg_next_s      = b_reg_r;
        par_bad_next_s    = par_bad_r;
        dout_next_s       = dout_r;
        done_next_s       = 1'b0;
        frame_err_next_s  = frame_err_r;
        parity_err_next_s = parity_err_r;
        case (state_r)
            IDLE: begin
                if (!rx_s) s_cnt_next_s = 5'd0;
                else       s_cnt_next_s = s_cnt_r;
            end
            START: begin
                if (!s_tick) begin
                    s_cnt_next_s = s_cnt_r;
                end else if (s_cnt_r == S_MID) begin
                    s_cnt_next_s = 5'd0;
                    n_cnt_next_s = 3'd0;
                end else begin
                    s_cnt_next_s = s_cnt_r + 5'd1;
                end
            end
            DATA: begin
                if (!s_tick) begin
                    s_cnt_next_s = s_cnt_r;
                end else if (s_cnt_r == S_BIT_LAST) begin
                    s_cnt_next_s = 5'd0;
                    b_reg_next_s = {rx_s, b_reg_r[DBIT-1:1]};
                    if (n_cnt_r == N_LAST) n_cnt_next_s = n_cnt_r;
                    else                   n_cnt_next_s = n_cnt_r + 3'd1;
                end else begin
                    s_cnt_next_s = s_cnt_r + 5'd1;
                end
            end
            PARITY: begin
                if (!s_tick) begin
                    s_cnt_next_s = s_cnt_r;
                end else if (s_cnt_r == S_BIT_LAST) begin
                    s_cnt_next_s   = 5'd0;
                    par_bad_next_s = parity_bad(^b_reg_r, rx_s, PAR_MODE);
                end else begin
                    s_cnt_next_s = s_cnt_r + 5'd1;
                end
            end
            STOP: begin
                if (!s_tick) begin
                    s_cnt_next_s = s_cnt_r;
                end else if (s_cnt_r == S_STOP_LAST) begin
                    s_cnt_next_s      = 5'd0;
                    dout_next_s       = b_reg_r;
                    frame_err_next_s  = ~rx_s;
                    parity_err_next_s = (PAR_MODE != PAR_NONE) ? par_bad_r : 1'b0;
                    done_next_s       = 1'b1;
                end else begin
                    s_cnt_next_s = s_cnt_r + 5'd1;
                end
            end
            default: begin
                s_cnt_next_s = 5'd0;
            end
        endcase
    end

    assign dout         = dout_r;
    assign rx_done_tick = done_r;
    assign frame_err    = frame_err_r;
    assign parity_err   = parity_err_r;

endmodule
